button_debounce: RTL
====================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter TICK_DIV, default 100000, sets clk cycles per debounce sample tick (1 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter DB_TICKS, default 20, sets the number of consecutive ticks an input must hold a new level before it is accepted; legal range >= 1.
REQ-003 clk  input  1  single system clock; all flops rise-edge clocked.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 btn_in  input  4  raw asynchronous push-button pins, active-high.
REQ-006 btn_level  output  4  debounced level per button.
REQ-007 btn_press  output  4  one-cycle pulse per button on accepted 0->1.
REQ-008 btn_release  output  4  one-cycle pulse per button on accepted 1->0.
REQ-009 any_press  output  1  registered OR of btn_press, delayed one cycle.

Function
REQ-010 Each btn_in bit SHALL pass through a 2-flop synchronizer; the second-stage output is sync[i].
REQ-011 A shared tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be high for exactly the one cycle in which the counter equals TICK_DIV-1.
REQ-012 Counter width SHALL be clog2(TICK_DIV); per-channel tick-count width SHALL be clog2(DB_TICKS+1); no counter shall overflow or saturate incorrectly.
REQ-013 Each channel SHALL run an independent FSM with states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-014 STABLE_LO: if sync=1, go to WAIT_HI with tick-count cleared to 0; else stay.
REQ-015 WAIT_HI: if sync=0, return to STABLE_LO with no output change (bounce rejected); else on each tick increment tick-count.
REQ-016 WAIT_HI: in the cycle where tick=1, sync=1 and tick-count=DB_TICKS-1, go to STABLE_HI; on the next edge btn_level[i]=1 and btn_press[i]=1 for exactly one cycle.
REQ-017 STABLE_HI and WAIT_LO SHALL mirror REQ-014..016 with polarity inverted, producing btn_level[i]=0 and btn_release[i] pulse.
REQ-018 Sync reverting in the same cycle as the qualifying tick SHALL take priority: transition rejected, return to the stable state.
REQ-019 Acceptance latency from a clean input edge SHALL be 2 sync cycles plus between (DB_TICKS-1)*TICK_DIV+1 and DB_TICKS*TICK_DIV cycles.
REQ-020 btn_press and btn_release for the same bit SHALL never be high in the same cycle; channels SHALL be fully independent, and simultaneous accepts on several bits SHALL pulse together.
REQ-021 btn_level SHALL change only in a cycle in which the corresponding press/release pulse is high.
REQ-022 Inputs held high continuously SHALL produce exactly one btn_press and no further pulses.

Reset
REQ-023 reset_n=0 SHALL immediately clear synchronizers, tick counter, tick-counts, and all outputs to 0, and force every FSM to STABLE_LO.
REQ-024 A reset asserted mid-WAIT SHALL discard the partial count; no pulse shall be emitted during or on release of reset.
REQ-025 After reset release, a button already held high SHALL be treated as a new 0->1 edge and debounced normally.
REQ-026 Reset deassertion SHALL be synchronized externally; the block assumes no metastability on reset_n release.

Verification (TICK_DIV=4, DB_TICKS=3)
REQ-027 Clean press: btn_in[0] 0->1 held -> btn_level[0]=1 and one btn_press[0] pulse within 2+9..2+12 cycles; any_press pulses one cycle later.
REQ-028 Bounce: btn_in[1] high for 6 cycles, low for 2, then high held -> no pulse until 3 full ticks after the final rise; exactly one press.
REQ-029 Release: after an accepted press, btn_in[0] 1->0 held -> one btn_release[0] pulse; btn_level[0]=0 in the same cycle.
REQ-030 Simultaneous: btn_in=4'b1111 in one cycle -> all four btn_press bits pulse in the same cycle; btn_level=4'b1111.
REQ-031 Reset mid-operation: assert reset_n=0 during WAIT_HI -> outputs 0 at once; after release with the input still high -> full debounce restarts with one press.
REQ-032 Glitch at tick: sync drops in the qualifying tick cycle -> no pulse, FSM returns to STABLE_LO, btn_level unchanged.

Source files
------------

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - four-channel push-button debouncer with press/release pulses
module button_debounce #(
    parameter int TICK_DIV = 100000,
    parameter int DB_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] btn_in,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic       any_press
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int TW = $clog2(DB_TICKS + 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [TW-1:0] CNT_LAST  = TW'(DB_TICKS - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } db_state_t;

    logic [3:0]    sync_q1;
    logic [3:0]    sync;
    logic [CW-1:0] tick_cnt;
    logic          tick;

    db_state_t     state     [4];
    db_state_t     state_nxt [4];
    logic [TW-1:0] cnt       [4];
    logic [TW-1:0] cnt_nxt   [4];
    logic [3:0]    press_nxt;
    logic [3:0]    release_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync    <= '0;
        end else begin
            sync_q1 <= btn_in;
            sync    <= sync_q1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CW'(1);
    end

    // A reverting sync input wins over a qualifying tick in the same cycle.
    always_comb begin
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                STABLE_LO: begin
                    if (sync[i]) begin
                        state_nxt[i] = WAIT_HI;
                        cnt_nxt[i]   = '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync[i]) begin
                        state_nxt[i] = STABLE_LO;
                    end else if (tick) begin
                        if (cnt[i] == CNT_LAST) begin
                            state_nxt[i] = STABLE_HI;
                            press_nxt[i] = 1'b1;
                        end else begin
                            cnt_nxt[i] = cnt[i] + TW'(1);
                        end
                    end
                end
                STABLE_HI: begin
                    if (!sync[i]) begin
                        state_nxt[i] = WAIT_LO;
                        cnt_nxt[i]   = '0;
                    end
                end
                WAIT_LO: begin
                    if (sync[i]) begin
                        state_nxt[i] = STABLE_HI;
                    end else if (tick) begin
                        if (cnt[i] == CNT_LAST) begin
                            state_nxt[i]   = STABLE_LO;
                            release_nxt[i] = 1'b1;
                        end else begin
                            cnt_nxt[i] = cnt[i] + TW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt[i] = STABLE_LO;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= STABLE_LO;
                cnt[i]   <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            any_press   <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            btn_level   <= (btn_level | press_nxt) & ~release_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
            any_press   <= |btn_press;
        end
    end

endmodule
